// File: rtl/prescale_ctrl.sv
// Multi-channel clock-enable prescaler: each channel emits a count-enable strobe
// once per (limit+1) clocks, or every clock in bypass, with debug freeze and restart.
module prescale_ctrl #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       timer_en,
  input  logic [NCH-1:0]       div_en,
  input  logic [NCH-1:0]       div_mode,
  input  logic [NCH*CNT_W-1:0] div_val,
  input  logic [NCH-1:0]       restart,
  input  logic                 dbg_halt,
  output logic [NCH-1:0]       count_en
);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] val;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             bypass;
    logic             term;

    assign val = div_val[i*CNT_W +: CNT_W];

    // NOTE: every signal written here gets a value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
      limit  = '0;
      bypass = 1'b0;
      term   = 1'b0;
      cnt_d  = cnt_q;

      // Shifting all-ones left by k clears k low bits; the inverse is 2^k-1, and
      // any k >= CNT_W shifts everything out, which saturates to all-ones.
      if (div_mode[i]) limit = val;
      else             limit = ~(ONES << val);

      bypass = !div_en[i] || (val == '0);
      term   = (cnt_q >= limit);

      if (!timer_en[i] || bypass || restart[i]) cnt_d = '0;
      else if (dbg_halt)                        cnt_d = cnt_q;
      else if (term)                            cnt_d = '0;
      else                                      cnt_d = cnt_q + ONE;
    end

    // NOTE: state is updated with non-blocking assignments only, so every channel
    // samples the pre-edge value of cnt_q regardless of process ordering.
    // NOTE: reset is synchronous; the counter is a plain register, so it is
    // cleared on the edge rather than asynchronously.
    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign count_en[i] = timer_en[i] && !dbg_halt && !restart[i] && (bypass || term);
  end

endmodule

// File: tb/tb_prescale_ctrl.sv
// Directed bench for prescale_ctrl: a combinational vector table under reset,
// then cycle-by-cycle sequences for divide, retune, halt, restart and reset.
module tb_prescale_ctrl;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   timer_en, div_en, div_mode, restart;
  logic [NCH*CNT_W-1:0] div_val;
  logic             dbg_halt;
  logic [NCH-1:0]   count_en;

  int passed = 0;
  int total  = 0;

  prescale_ctrl #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_mode (div_mode),
    .div_val  (div_val),
    .restart  (restart),
    .dbg_halt (dbg_halt),
    .count_en (count_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]       te;
    logic [NCH-1:0]       de;
    logic [NCH-1:0]       dm;
    logic [NCH-1:0]       rs;
    logic                 halt;
    logic [NCH*CNT_W-1:0] dv;
    logic [NCH-1:0]       exp_ce;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: count_en=%b expected %b", name, act, exp_v);
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    timer_en = '0;
    div_en   = '0;
    div_mode = '0;
    restart  = '0;
    dbg_halt = 1'b0;
    div_val  = '0;
  endtask

  // Returns in cycle 0 of a fresh run: all counters are 0 and inputs idle.
  task automatic apply_reset();
    next_cycle();
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NCH-1:0] exp_v;

    tbl[0] = '{te:4'h0, de:4'h0, dm:4'h0, rs:4'h0, halt:1'b0, dv:32'h0,        exp_ce:4'h0};
    tbl[1] = '{te:4'hF, de:4'h0, dm:4'h0, rs:4'h0, halt:1'b0, dv:32'h0,        exp_ce:4'hF};
    tbl[2] = '{te:4'hF, de:4'hF, dm:4'h0, rs:4'h0, halt:1'b0, dv:32'h03030303, exp_ce:4'h0};
    tbl[3] = '{te:4'hF, de:4'hF, dm:4'hF, rs:4'h0, halt:1'b0, dv:32'h0,        exp_ce:4'hF};
    tbl[4] = '{te:4'hF, de:4'h0, dm:4'h0, rs:4'h0, halt:1'b1, dv:32'h0,        exp_ce:4'h0};
    tbl[5] = '{te:4'hF, de:4'h0, dm:4'h0, rs:4'h5, halt:1'b0, dv:32'h0,        exp_ce:4'hA};
    tbl[6] = '{te:4'h3, de:4'h5, dm:4'h0, rs:4'h0, halt:1'b0, dv:32'h03030303, exp_ce:4'h2};
    tbl[7] = '{te:4'hF, de:4'hF, dm:4'hA, rs:4'h0, halt:1'b0, dv:32'h05050500, exp_ce:4'h1};
    tbl[8] = '{te:4'h5, de:4'hF, dm:4'hF, rs:4'h0, halt:1'b0, dv:32'hC8C8C8C8, exp_ce:4'h0};

    rst_n = 1'b0;
    idle_inputs();
    next_cycle();

    // Held in reset: counters stay 0, so only bypass channels may strobe.
    for (int v = 0; v < 9; v++) begin
      next_cycle();
      timer_en = tbl[v].te;
      div_en   = tbl[v].de;
      div_mode = tbl[v].dm;
      restart  = tbl[v].rs;
      dbg_halt = tbl[v].halt;
      div_val  = tbl[v].dv;
      settle();
      check($sformatf("table[%0d]", v), count_en, tbl[v].exp_ce);
    end

    // Ch0 pow2 k=3 (period 8), ch1 linear 4 (period 5), ch2 pow2 k=13 saturates to 255 (period 256).
    apply_reset();
    timer_en = 4'b0111;
    div_en   = 4'b0111;
    div_mode = 4'b0010;
    div_val  = {8'd0, 8'd13, 8'd4, 8'd3};
    for (int c = 0; c < 520; c++) begin
      if (c > 0) next_cycle();
      settle();
      exp_v = {1'b0, (c % 256) == 255, (c % 5) == 4, (c % 8) == 7};
      check($sformatf("divide c=%0d", c), count_en, exp_v);
    end

    // Linear 100 lowered to 10 while cnt=50: terminal compare fires in that cycle.
    apply_reset();
    timer_en = 4'b1000;
    div_en   = 4'b1000;
    div_mode = 4'b1000;
    div_val  = {8'd100, 24'd0};
    for (int c = 0; c < 76; c++) begin
      if (c > 0) next_cycle();
      if (c == 50) div_val[31:24] = 8'd10;
      settle();
      exp_v = (c == 50 || c == 61 || c == 72) ? 4'b1000 : 4'b0000;
      check($sformatf("retune c=%0d", c), count_en, exp_v);
    end

    // Halt for 20 cycles at cnt=2 (limit 7); ch1 in bypass is suppressed too.
    apply_reset();
    timer_en = 4'b0011;
    div_en   = 4'b0001;
    div_val  = {24'd0, 8'd3};
    for (int c = 0; c < 31; c++) begin
      if (c > 0) next_cycle();
      if (c == 2)  dbg_halt = 1'b1;
      if (c == 22) dbg_halt = 1'b0;
      settle();
      exp_v = {2'b00, !dbg_halt, c == 27};
      check($sformatf("halt c=%0d", c), count_en, exp_v);
    end

    // Restart with halt at cnt=5: restart wins, counting resumes from 0 next cycle.
    apply_reset();
    timer_en = 4'b0001;
    div_en   = 4'b0001;
    div_val  = {24'd0, 8'd3};
    for (int c = 0; c < 17; c++) begin
      if (c > 0) next_cycle();
      restart  = (c == 5) ? 4'b0001 : 4'b0000;
      dbg_halt = (c == 5);
      settle();
      exp_v = {3'b000, c == 13};
      check($sformatf("restart c=%0d", c), count_en, exp_v);
    end

    // Undivided mode: count_en mirrors timer_en every cycle.
    div_en  = 4'b0000;
    div_val = 32'h03030303;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      timer_en = 4'(c * 5 + 3);
      settle();
      check($sformatf("bypass c=%0d", c), count_en, 4'(c * 5 + 3));
    end

    // One-clock reset at cnt=6 (limit 7): no strobe at cycle 7, next at 14.
    apply_reset();
    timer_en = 4'b0001;
    div_en   = 4'b0001;
    div_val  = {24'd0, 8'd3};
    for (int c = 0; c < 24; c++) begin
      if (c > 0) next_cycle();
      if (c == 6) rst_n = 1'b0;
      if (c == 7) rst_n = 1'b1;
      settle();
      exp_v = {3'b000, c == 14 || c == 22};
      check($sformatf("midreset c=%0d", c), count_en, exp_v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
